// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack port, and runs a
// FETCH/EXEC handshake with the control unit. A stalled fetch ends in a sticky FAULT.
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_inc,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               exec,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        retired,
  output logic               fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        retired_q, retired_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          wait_d  = '0;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_q + CNT_W'(1);
          // wait_q counts cycles already spent, so this is the TIMEOUT-th miss
          if (wait_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        pc_d      = s_inc ? pc_q + PC_W'(1) : instr_q[PC_W-1:0];
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
      end
      default: ;
    endcase
  end

  // Reset gates the strobes combinationally so nothing leaks out while it is held.
  assign mem_req  = (state_q == S_FETCH) && !reset;
  assign exec     = (state_q == S_EXEC) && !reset;
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[INSTR_W-1:INSTR_W-6];
  assign retired  = retired_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a bench-side program memory and control-unit
// model drive fetches; expected instruction / next PC are queued at ack time.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 16;

  logic               clk;
  logic               reset;
  logic               s_inc;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [5:0]         opcode;
  logic               exec;
  logic [PC_W-1:0]    pc;
  logic [15:0]        retired;
  logic               fault;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .s_inc(s_inc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .opcode(opcode), .exec(exec), .pc(pc),
    .retired(retired), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    nxt;
  } sb_item_t;

  sb_item_t           sb[$];
  logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
  logic [INSTR_W-1:0] last_instr;
  logic [15:0]        ret_model;
  int                 n_checks;
  int                 n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered at the falling edge of the first FETCH cycle; returns at the
  // falling edge of the following FETCH cycle.
  task automatic run_instr(input logic [PC_W-1:0] addr, input int waits,
                           input logic sinc, input logic junk,
                           output logic [PC_W-1:0] next_addr);
    sb_item_t           it;
    logic [INSTR_W-1:0] w;
    for (int i = 0; i < waits; i++) begin
      check("wait_req", mem_req, 1);
      check("wait_addr", mem_addr, addr);
      check("wait_exec", exec, 0);
      check("wait_instr", instr, last_instr);
      mem_ack   = 1'b0;
      mem_rdata = INSTR_W'($urandom);
      @(negedge clk);
    end
    check("fetch_req", mem_req, 1);
    check("fetch_addr", mem_addr, addr);
    check("fetch_exec", exec, 0);
    w         = mem[addr];
    mem_ack   = 1'b1;
    mem_rdata = w;
    it.instr  = w;
    it.nxt    = sinc ? addr + 10'd1 : w[PC_W-1:0];
    sb.push_back(it);
    @(negedge clk);
    check("exec_hi", exec, 1);
    check("exec_req", mem_req, 0);
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
      next_addr = addr;
    end else begin
      it = sb.pop_front();
      check("exec_instr", instr, it.instr);
      check("exec_opcode", opcode, it.instr[INSTR_W-1:INSTR_W-6]);
      check("exec_pc", pc, addr);
      check("exec_retired", retired, ret_model);
      last_instr = it.instr;
      next_addr  = it.nxt;
    end
    s_inc     = sinc;
    mem_ack   = junk;
    mem_rdata = ~w;
    ret_model = ret_model + 16'd1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_exec"}, exec, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [PC_W-1:0] a;
    n_checks   = 0;
    n_fail     = 0;
    ret_model  = 16'd0;
    last_instr = '0;
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = INSTR_W'((i * 16'h2B5) ^ 16'hA5A5);
    mem[3]     = 16'h1035;
    mem[10'h038] = 16'h0BFF;
    reset     = 1'b1;
    s_inc     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    @(negedge clk);
    check_reset_outputs("rst1");
    check("rst1_opcode", opcode, 0);
    @(negedge clk);
    check_reset_outputs("rst2");
    reset = 1'b0;
    #1;

    // zero-wait sequential run, then the jump at address 3
    a = '0;
    for (int i = 0; i < 3; i++) run_instr(a, 0, 1'b1, 1'b0, a);
    run_instr(a, 0, 1'b0, 1'b0, a);
    check("retired_after_4", retired, 4);

    // three wait states per fetch with ack noise during EXEC
    run_instr(a, 3, 1'b1, 1'b1, a);
    run_instr(a, 3, 1'b1, 1'b1, a);

    // ack in the last permitted cycle is accepted
    run_instr(a, TIMEOUT - 1, 1'b1, 1'b0, a);
    check("toA_fault", fault, 0);

    // jump to 3FF, then increment wraps to 0
    run_instr(a, 0, 1'b0, 1'b0, a);
    run_instr(a, 0, 1'b1, 1'b0, a);
    run_instr(a, 0, 1'b1, 1'b0, a);

    // no ack for TIMEOUT cycles
    for (int i = 0; i < TIMEOUT; i++) begin
      check("toB_req", mem_req, 1);
      check("toB_nofault", fault, 0);
      mem_ack = 1'b0;
      @(negedge clk);
    end
    check("toB_fault", fault, 1);
    check("toB_req_off", mem_req, 0);
    check("toB_exec", exec, 0);
    check("toB_pc", pc, a);
    for (int i = 0; i < 3; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      check("toC_fault", fault, 1);
      check("toC_req", mem_req, 0);
      check("toC_instr", instr, last_instr);
      check("toC_pc", pc, a);
      check("toC_retired", retired, ret_model);
    end

    // reset clears FAULT
    mem_ack = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst3");
    reset = 1'b0;
    #1;
    ret_model  = 16'd0;
    last_instr = '0;
    a = '0;
    run_instr(a, 0, 1'b1, 1'b0, a);

    // reset during a waiting fetch, with an ack in the same cycle
    for (int i = 0; i < 2; i++) begin
      mem_ack = 1'b0;
      @(negedge clk);
    end
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    check_reset_outputs("rst4");
    reset   = 1'b0;
    mem_ack = 1'b0;
    #1;
    ret_model  = 16'd0;
    last_instr = '0;
    a = '0;
    run_instr(a, 1, 1'b1, 1'b0, a);
    run_instr(a, 0, 1'b1, 1'b0, a);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the basic CPU; sits directly upstream of the control unit. Holds the program counter, fetches one instruction per step from program memory over a req/ack interface, presents the opcode to the control unit, and updates the PC from the control unit's `s_inc` decision. Every instruction takes a FETCH phase followed by a one-cycle EXEC phase. The `exec` pulse gates the datapath's register-file and flag writes.

## Interface
- `PC_W`, default 10: program counter / program memory address width.
- `INSTR_W`, default 16: instruction width; must be ≥ `PC_W` + 6.
- `TIMEOUT`, default 16: maximum wait cycles for `mem_ack` before fault; must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `s_inc` in 1: from control unit.
  - 1 → PC+1.
  - 0 → jump to `instr[PC_W-1:0]`.
- `mem_req` out 1: fetch request to program memory.
- `mem_addr` out `PC_W`: fetch address; equals `pc`.
- `mem_ack` in 1: read data valid, sampled only while `mem_req`=1.
- `mem_rdata` in `INSTR_W`: instruction word, valid when `mem_ack`=1.
- `instr` out `INSTR_W`: instruction register.
- `opcode` out 6: `instr[INSTR_W-1:INSTR_W-6]`, to control unit.
- `exec` out 1: high for exactly the EXEC cycle.
- `pc` out `PC_W`: current program counter.
- `retired` out 16: count of completed EXEC cycles.
- `fault` out 1: fetch timeout occurred; sticky until reset.

## Operation
- States: FETCH, EXEC, FAULT.
- Reset (sampled high at an edge) sets:
  - state=FETCH, `pc`=0, `instr`=0, `retired`=0, `fault`=0, wait counter=0.
  - Outputs while `reset` is high: `mem_req`=0, `exec`=0.
- FETCH:
  - `mem_req`=1 combinationally; `mem_addr`=`pc`.
  - Edge with `mem_ack`=1:
    - `instr` <= `mem_rdata`; wait counter <= 0.
    - state <= EXEC.
  - Edge with `mem_ack`=0:
    - wait counter += 1.
    - If the wait counter was `TIMEOUT`-1: state <= FAULT, `fault` <= 1.
- EXEC:
  - `mem_req`=0, `exec`=1; `instr` and `opcode` held stable.
  - The control unit decodes combinationally; `s_inc` is sampled at the closing edge.
  - `pc` <= `s_inc` ? `pc`+1 : `instr[PC_W-1:0]`.
  - `retired` += 1; state <= FETCH.
- FAULT:
  - `mem_req`=0, `exec`=0, `fault`=1.
  - `pc`, `instr` and `retired` are frozen.
  - Exit only by reset.
- Arithmetic and wrap rules:
  - `pc`+1 wraps modulo 2^`PC_W` (all-ones → 0).
  - `retired` wraps 0xFFFF → 0.
- Undecoded opcodes:
  - The control unit returns `s_inc`=0 for them, so they jump to `instr[PC_W-1:0]`.
  - This is intended; no trap.
- `mem_ack` outside FETCH is ignored; `mem_rdata` is not captured.
- Reset has priority over every state and event, including an edge where `mem_ack`=1 or the timeout expires.

## Timing
- Zero-wait memory (ack in the first FETCH cycle): 2 cycles per instruction, FETCH then EXEC.
- N wait cycles: N+2 cycles per instruction.
- First `mem_req`: the first cycle after `reset` deasserts, with `mem_addr`=0.
- `exec` is never high in two consecutive cycles; `mem_req` and `exec` are never high together.
- `pc` changes only on the edge closing EXEC; `mem_addr` is stable through all of FETCH.
- Timeout:
  - `fault` rises on the edge ending the `TIMEOUT`-th consecutive FETCH cycle without ack.
  - An ack in cycle `TIMEOUT` itself is accepted, with no fault.
- Reset mid-FETCH or mid-EXEC: the in-flight instruction is abandoned, `retired` is not incremented, and fetch restarts at address 0.

## Test plan
- Reset and zero-wait run:
  - Stimulus: hold `reset` 2 cycles, memory acks immediately, `s_inc`=1.
  - Required: `mem_addr` sequence 0,1,2,3; `exec` pulses every 2nd cycle; `retired`=4 after 8 cycles; all outputs 0 during reset.
- Jump:
  - Stimulus: instruction at address 3 = 16'h1035, `s_inc`=0 in its EXEC.
  - Required: next `mem_addr`=10'h035; `opcode` during that EXEC = 6'b000100.
- Wait states:
  - Stimulus: ack delayed 3 cycles on each fetch.
  - Required: 5 cycles per instruction; `instr` updates only on ack; `mem_addr` held constant while waiting.
- Timeout boundary:
  - Stimulus A: ack arrives in cycle 16 → required: instruction accepted, `fault`=0.
  - Stimulus B: no ack for 16 cycles → required: `fault`=1, `mem_req`=0, `pc` frozen.
  - Stimulus C: a later ack in FAULT → required: ignored.
- PC wrap and reset mid-operation:
  - Stimulus: `pc`=10'h3FF with `s_inc`=1.
  - Required: next `mem_addr`=0.
  - Stimulus: assert `reset` during a waiting FETCH.
  - Required: `retired` cleared, fetch restarts at 0, and a pending ack in the reset cycle is discarded.
